// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a byte buffer and sticky error flags.
// Optional macro SC64_UART_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO;
// without it the buffer is a single holding register.
// Ports: clk, reset_n (async, active-low), uart_rxd (raw line),
//   rx_data/rx_valid/rx_read/rx_level (show-ahead buffer),
//   frame_error/overrun (sticky), error_clear, busy (frame in progress).
module uart_rx #(
   parameter int CLOCK_FREQUENCY = 100_000_000,
   parameter int BAUD_RATE       = 1_000_000,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            uart_rxd,
   output logic [7:0]                      rx_data,
   output logic                            rx_valid,
   input  logic                            rx_read,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_level,
   output logic                            frame_error,
   output logic                            overrun,
   input  logic                            error_clear,
   output logic                            busy
);
   localparam int BIT_PERIOD = CLOCK_FREQUENCY / BAUD_RATE;
   localparam int CW = $clog2(BIT_PERIOD);
   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_PERIOD / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_PERIOD - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;

   logic          rxd_meta;
   logic          rxd_sync;
   logic          rxd_prev;
   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          fall;
   logic          sample;
   logic          push;
   logic          stop_bad;
   logic          full;
   logic          pop;
   logic          do_push;
   logic          ovr_evt;

   // Synchronizer and edge history all idle high out of reset,
   // so releasing reset can never look like a start edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rxd_meta <= uart_rxd;
         rxd_sync <= rxd_meta;
         rxd_prev <= rxd_sync;
      end
   end

   assign fall     = rxd_prev & ~rxd_sync;
   assign sample   = (cnt == '0);
   assign push     = (state == ST_STOP) & sample & rxd_sync;
   assign stop_bad = (state == ST_STOP) & sample & ~rxd_sync;
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         if (state == ST_START || state == ST_DATA || state == ST_STOP)
            cnt <= sample ? FULL_LOAD : cnt - CW'(1);
         unique case (state)
            ST_IDLE: begin
               if (fall) begin
                  state <= ST_START;
                  cnt   <= HALF_LOAD;
               end
            end
            ST_START: begin
               if (sample) begin
                  if (rxd_sync) begin
                     state <= ST_IDLE;
                  end else begin
                     state   <= ST_DATA;
                     bit_idx <= '0;
                  end
               end
            end
            ST_DATA: begin
               if (sample) begin
                  shreg   <= {rxd_sync, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7)
                     state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (sample)
                  state <= rxd_sync ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK: begin
               if (rxd_sync)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A pop in the push cycle frees the slot, so a full buffer still
   // accepts the byte.
   assign pop     = rx_read & rx_valid;
   assign do_push = push & (~full | pop);
   assign ovr_evt = push & full & ~pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_error <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         frame_error <= stop_bad | (frame_error & ~error_clear);
         overrun     <= ovr_evt | (overrun & ~error_clear);
      end
   end

`ifdef SC64_UART_RX_FIFO_EN
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level;

   assign full     = (level == LW'(FIFO_DEPTH));
   assign rx_valid = (level != '0);
   assign rx_level = level;
   assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= shreg;
   end
`else
   logic [7:0] hold;
   logic       hold_valid;

   assign full     = hold_valid;
   assign rx_valid = hold_valid;
   assign rx_level = LW'(hold_valid);
   assign rx_data  = hold;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold       <= 8'h00;
         hold_valid <= 1'b0;
      end else if (do_push) begin
         hold       <= shreg;
         hold_valid <= 1'b1;
      end else if (pop) begin
         hold_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames checked against a queue model
// of the receive buffer and its sticky flags.
module tb_uart_rx;
   localparam int BP = 100;
`ifdef SC64_UART_RX_FIFO_EN
   localparam int CAP = 8;
`else
   localparam int CAP = 1;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       uart_rxd = 1'b1;
   logic       rx_read = 1'b0;
   logic       error_clear = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [3:0] rx_level;
   logic       frame_error;
   logic       overrun;
   logic       busy;

   int n_tests = 0;
   int n_fail = 0;
   byte unsigned q[$];
   logic m_fe = 1'b0;
   logic m_ovr = 1'b0;
   logic [7:0] last_pop = 8'h00;

   uart_rx dut (
      .clk(clk), .reset_n(reset_n), .uart_rxd(uart_rxd),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_read(rx_read),
      .rx_level(rx_level), .frame_error(frame_error),
      .overrun(overrun), .error_clear(error_clear), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_level"}, 32'(rx_level), q.size());
      chk({tag, "_valid"}, 32'(rx_valid), 32'(q.size() != 0));
      chk({tag, "_fe"}, 32'(frame_error), 32'(m_fe));
      chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
      chk({tag, "_busy"}, 32'(busy), 0);
      if (q.size() != 0)
         chk({tag, "_data"}, 32'(rx_data), 32'(q[0]));
   endtask

   // One frame; the pin is driven at cycle 0 so the stop sample falls
   // in cycle 952 and the pushed byte shows in cycle 953.
   task automatic send_byte(input logic [7:0] d, input int stop_low,
                            input int read_at, input bit lat);
      int total;
      bit popped;
      total = 1000 + stop_low + 20;
      popped = 0;
      for (int c = 0; c < total; c++) begin
         if (c < 100)
            uart_rxd = 1'b0;
         else if (c < 900)
            uart_rxd = d[(c - 100) / 100];
         else
            uart_rxd = (c < 900 + stop_low) ? 1'b0 : 1'b1;
         rx_read = (c == read_at);
         if (c == read_at && q.size() != 0) begin
            chk("push_pop_data", 32'(rx_data), 32'(q[0]));
            last_pop = q.pop_front();
            popped = 1;
         end
         if (lat) begin
            if (c == 2) chk("busy_at_d", 32'(busy), 0);
            if (c == 3) chk("busy_after_d", 32'(busy), 1);
            if (c == 952) chk("valid_at_stop", 32'(rx_valid), 0);
            if (c == 953) begin
               chk("valid_d951", 32'(rx_valid), 1);
               chk("data_d951", 32'(rx_data), 32'(d));
               chk("level_d951", 32'(rx_level), 1);
               chk("busy_fall", 32'(busy), 0);
            end
         end
         tick();
         rx_read = 1'b0;
      end
      if (stop_low > BP / 2)
         m_fe = 1'b1;
      else if (q.size() < CAP)
         q.push_back(d);
      else
         m_ovr = 1'b1;
      if (popped && read_at >= 0)
         chk("no_underflow_pp", 32'(q.size() <= CAP), 1);
   endtask

   task automatic pop_chk(input string tag);
      if (q.size() != 0) begin
         chk({tag, "_pop"}, 32'(rx_data), 32'(q[0]));
         last_pop = q.pop_front();
         rx_read = 1'b1;
         tick();
         rx_read = 1'b0;
         check_state(tag);
      end
   endtask

   task automatic clear_errors();
      error_clear = 1'b1;
      tick();
      error_clear = 1'b0;
      m_fe = 1'b0;
      m_ovr = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      repeat (3) tick();
      chk("rst_data", 32'(rx_data), 0);
      chk("rst_valid", 32'(rx_valid), 0);
      chk("rst_level", 32'(rx_level), 0);
      chk("rst_fe", 32'(frame_error), 0);
      chk("rst_ovr", 32'(overrun), 0);
      chk("rst_busy", 32'(busy), 0);
      reset_n = 1'b1;
      repeat (3) tick();

      // basic byte with exact latency
      send_byte(8'hA5, 0, -1, 1);
      check_state("a5");
      pop_chk("a5");
      rx_read = 1'b1;
      tick();
      rx_read = 1'b0;
      check_state("empty_read");

      // short low glitch is a false start
      for (int c = 0; c < 120; c++) begin
         uart_rxd = (c < 30) ? 1'b0 : 1'b1;
         if (c == 10) chk("glitch_busy", 32'(busy), 1);
         if (c == 60) chk("glitch_idle", 32'(busy), 0);
         tick();
      end
      check_state("glitch");

      // framing error, then recovery
      send_byte(8'h3C, 300, -1, 0);
      check_state("fe");
      send_byte(8'h55, 0, -1, 0);
      check_state("after_fe");
      clear_errors();
      check_state("fe_clr");
      while (q.size() != 0) pop_chk("drain1");

      // overrun: CAP+1 bytes with no reads
      for (int i = 0; i <= CAP; i++)
         send_byte(8'(i), 0, -1, 0);
      check_state("ovr");
      while (q.size() != 0) pop_chk("ovr_rd");
      clear_errors();
      check_state("ovr_clr");

      // full buffer with pop on the push cycle
      for (int i = 0; i < CAP; i++)
         send_byte(8'(8'h10 + i), 0, -1, 0);
      send_byte(8'h77, 0, 952, 0);
      check_state("pp");
      while (q.size() != 0) pop_chk("pp_rd");
      chk("pp_last", 32'(last_pop), 32'h77);

      // reset in the middle of bit 4
      d = 8'hE7;
      for (int c = 0; c < 550; c++) begin
         uart_rxd = (c < 100) ? 1'b0 : d[(c - 100) / 100];
         tick();
      end
      chk("mid_busy", 32'(busy), 1);
      reset_n = 1'b0;
      uart_rxd = 1'b1;
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (3) tick();
      q.delete();
      m_fe = 1'b0;
      m_ovr = 1'b0;
      check_state("post_rst");
      send_byte(8'h81, 0, -1, 0);
      check_state("b81");
      pop_chk("b81");

      // random traffic
      for (int n = 0; n < 12; n++) begin
         d = 8'($urandom);
         send_byte(d, ($urandom_range(0, 5) == 0) ? 300 : 0, -1, 0);
         check_state("rnd");
         for (int k = $urandom_range(0, 2); k > 0; k--)
            pop_chk("rnd_rd");
         if ((m_fe || m_ovr) && $urandom_range(0, 1) == 1) begin
            clear_errors();
            check_state("rnd_clr");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
